// File: rtl/fpnew_classifier_multi.sv
// fpnew_classifier_multi: CLASS opgroup slice. Unpacks raw operand bits into
// per-lane one-hot classification masks (bit 0 NEGINF ... bit 9 QNAN) for
// FP32/FP64/FP16/FP8/FP16ALT, scalar with NaN-box check or packed vector,
// behind a valid/ready pipeline with collapsing bubbles.
module fpnew_classifier_multi #(
  parameter int WIDTH          = 64,
  parameter int ENABLE_VECTORS = 1,
  parameter int NUM_PIPE_REGS  = 1,
  parameter int TAG_WIDTH      = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [WIDTH-1:0]          operand_i,
  input  logic [2:0]                fmt_i,
  input  logic [TAG_WIDTH-1:0]      tag_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic                      flush_i,
  output logic [10*(WIDTH/8)-1:0]   class_o,
  output logic [WIDTH/8-1:0]        lane_mask_o,
  output logic                      illegal_fmt_o,
  output logic [TAG_WIDTH-1:0]      tag_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic                      busy_o
);

  localparam int NL = WIDTH / 8;  // widest lane count (FP8)
  localparam int NF = 5;          // number of legal formats

  function automatic int fmt_exp(input int f);
    case (f)
      0:       return 8;
      1:       return 11;
      2:       return 5;
      3:       return 5;
      4:       return 8;
      default: return 8;
    endcase
  endfunction

  function automatic int fmt_man(input int f);
    case (f)
      0:       return 23;
      1:       return 52;
      2:       return 10;
      3:       return 2;
      4:       return 7;
      default: return 7;
    endcase
  endfunction

  // One-hot class code from the decoded exponent/mantissa properties.
  function automatic logic [9:0] class_bits(input logic sign, input logic exp_ones,
                                            input logic exp_zero, input logic man_zero,
                                            input logic man_msb);
    logic [9:0] c;
    if (exp_ones) begin
      if (man_zero) c = sign ? 10'h001 : 10'h080;
      else          c = man_msb ? 10'h200 : 10'h100;
    end else if (exp_zero) begin
      if (man_zero) c = sign ? 10'h008 : 10'h010;
      else          c = sign ? 10'h004 : 10'h020;
    end else begin
      c = sign ? 10'h002 : 10'h040;
    end
    return c;
  endfunction

  // Classify one right-aligned lane of ew exponent and mw mantissa bits.
  function automatic logic [9:0] classify_lane(input logic [63:0] bits, input int ew,
                                               input int mw);
    logic e1, e0, mz;
    e1 = 1'b1;
    e0 = 1'b1;
    mz = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i < mw) begin
        mz = mz & ~bits[6'(i)];
      end else if (i < mw + ew) begin
        e1 = e1 & bits[6'(i)];
        e0 = e0 & ~bits[6'(i)];
      end else begin
        e1 = e1;
      end
    end
    return class_bits(bits[6'(ew + mw)], e1, e0, mz, bits[6'(mw - 1)]);
  endfunction

  typedef struct packed {
    logic [10*NL-1:0]     cls;
    logic [NL-1:0]        mask;
    logic                 ill;
    logic [TAG_WIDTH-1:0] tag;
  } stage_t;

  logic [9:0] cls_s   [NF][NL];
  logic       lmask_s [NF][NL];

  // Per-format, per-lane classifiers; unused lanes are tied to zero.
  for (genvar f = 0; f < NF; f++) begin : g_fmt
    localparam int EW  = fmt_exp(f);
    localparam int MW  = fmt_man(f);
    localparam int FW  = 1 + EW + MW;
    localparam int NLF = (ENABLE_VECTORS != 0) ? (WIDTH / FW) : 1;
    for (genvar k = 0; k < NL; k++) begin : g_lane
      if (k < NLF) begin : g_used
        logic [63:0] slice_s;
        assign slice_s = 64'(operand_i[k*FW +: FW]);
        if (ENABLE_VECTORS == 0 && FW < WIDTH) begin : g_box
          // A scalar narrower than the register must be NaN-boxed (upper bits all ones).
          assign cls_s[f][k] = (&operand_i[WIDTH-1:FW]) ? classify_lane(slice_s, EW, MW)
                                                        : 10'h200;
        end else begin : g_nobox
          assign cls_s[f][k] = classify_lane(slice_s, EW, MW);
        end
        assign lmask_s[f][k] = 1'b1;
      end else begin : g_unused
        assign cls_s[f][k]   = 10'h000;
        assign lmask_s[f][k] = 1'b0;
      end
    end
  end

  stage_t     in_data_s;
  logic [2:0] sel_s;

  // Select the classifier bank for fmt_i; illegal formats yield an empty result.
  always_comb begin
    in_data_s     = '0;
    in_data_s.tag = tag_i;
    sel_s         = 3'd0;
    case (fmt_i)
      3'd0, 3'd1, 3'd2, 3'd3, 3'd4: begin
        sel_s = fmt_i;
        for (int k = 0; k < NL; k++) begin
          in_data_s.cls[10*k +: 10] = cls_s[sel_s][k];
          in_data_s.mask[k]         = lmask_s[sel_s][k];
        end
      end
      default: in_data_s.ill = 1'b1;
    endcase
  end

  if (NUM_PIPE_REGS == 0) begin : g_comb
    assign in_ready_o    = out_ready_i;
    assign out_valid_o   = in_valid_i;
    assign class_o       = in_data_s.cls;
    assign lane_mask_o   = in_data_s.mask;
    assign illegal_fmt_o = in_data_s.ill;
    assign tag_o         = in_data_s.tag;
    assign busy_o        = 1'b0;
  end else begin : g_pipe
    localparam int N = NUM_PIPE_REGS;
    stage_t       data_q [N];
    stage_t       prev_data_s [N];
    logic [N-1:0] valid_q;
    logic [N-1:0] prev_valid_s;
    logic [N-1:0] ld_s;

    // Load enables ripple back from the output: a stage moves when empty or when its successor moves.
    always_comb begin
      ld_s = '0;
      ld_s[N-1] = ~valid_q[N-1] | out_ready_i;
      for (int i = N - 2; i >= 0; i--) begin
        ld_s[i] = ~valid_q[i] | ld_s[i+1];
      end
    end

    // What each stage would capture: the input for stage 0, otherwise the previous stage.
    always_comb begin
      prev_valid_s    = '0;
      prev_valid_s[0] = in_valid_i;
      prev_data_s[0]  = in_data_s;
      for (int i = 1; i < N; i++) begin
        prev_valid_s[i] = valid_q[i-1];
        prev_data_s[i]  = data_q[i-1];
      end
    end

    // Stage registers; flush drops every valid bit including the one being captured.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        valid_q <= '0;
        for (int i = 0; i < N; i++) data_q[i] <= '0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (ld_s[i]) begin
            valid_q[i] <= prev_valid_s[i] & ~flush_i;
            if (prev_valid_s[i]) data_q[i] <= prev_data_s[i];
          end else begin
            valid_q[i] <= valid_q[i] & ~flush_i;
          end
        end
      end
    end

    assign in_ready_o    = ld_s[0];
    assign out_valid_o   = valid_q[N-1];
    assign class_o       = data_q[N-1].cls;
    assign lane_mask_o   = data_q[N-1].mask;
    assign illegal_fmt_o = data_q[N-1].ill;
    assign tag_o         = data_q[N-1].tag;
    assign busy_o        = |valid_q;
  end

endmodule

// File: tb/tb_fpnew_classifier_multi.sv
// Bench for fpnew_classifier_multi: three instances (vector N=1, scalar
// NaN-boxed N=1, vector N=2) sharing operand/fmt/tag/flush/reset, with
// a queue-based scoreboard per instance.
module tb_fpnew_classifier_multi;

  typedef struct packed {
    logic [79:0] cls;
    logic [7:0]  mask;
    logic        ill;
    logic [3:0]  tag;
  } res_t;

  typedef struct {
    int          d;
    logic [63:0] op;
    logic [2:0]  f;
    logic [79:0] cls;
    logic [7:0]  mask;
    logic        ill;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [63:0] operand;
  logic [2:0]  fmt;
  logic [3:0]  tag;
  logic [2:0]  vld, rdy, in_rdy, ov, ill_o, busy;
  logic [79:0] cls0, cls1, cls2;
  logic [7:0]  lm0, lm1, lm2;
  logic [3:0]  tg0, tg1, tg2;

  int checks = 0;
  int errors = 0;
  res_t q0[$], q1[$], q2[$];
  vec_t tv[16];

  always #5 clk = ~clk;

  fpnew_classifier_multi #(.WIDTH(64), .ENABLE_VECTORS(1), .NUM_PIPE_REGS(1), .TAG_WIDTH(4)) u_vec (
    .clk_i(clk), .rst_i(rst), .operand_i(operand), .fmt_i(fmt), .tag_i(tag),
    .in_valid_i(vld[0]), .in_ready_o(in_rdy[0]), .flush_i(flush), .class_o(cls0),
    .lane_mask_o(lm0), .illegal_fmt_o(ill_o[0]), .tag_o(tg0), .out_valid_o(ov[0]),
    .out_ready_i(rdy[0]), .busy_o(busy[0]));

  fpnew_classifier_multi #(.WIDTH(64), .ENABLE_VECTORS(0), .NUM_PIPE_REGS(1), .TAG_WIDTH(4)) u_box (
    .clk_i(clk), .rst_i(rst), .operand_i(operand), .fmt_i(fmt), .tag_i(tag),
    .in_valid_i(vld[1]), .in_ready_o(in_rdy[1]), .flush_i(flush), .class_o(cls1),
    .lane_mask_o(lm1), .illegal_fmt_o(ill_o[1]), .tag_o(tg1), .out_valid_o(ov[1]),
    .out_ready_i(rdy[1]), .busy_o(busy[1]));

  fpnew_classifier_multi #(.WIDTH(64), .ENABLE_VECTORS(1), .NUM_PIPE_REGS(2), .TAG_WIDTH(4)) u_p2 (
    .clk_i(clk), .rst_i(rst), .operand_i(operand), .fmt_i(fmt), .tag_i(tag),
    .in_valid_i(vld[2]), .in_ready_o(in_rdy[2]), .flush_i(flush), .class_o(cls2),
    .lane_mask_o(lm2), .illegal_fmt_o(ill_o[2]), .tag_o(tg2), .out_valid_o(ov[2]),
    .out_ready_i(rdy[2]), .busy_o(busy[2]));

  function automatic res_t cur(input int d);
    res_t r;
    case (d)
      0:       r = {cls0, lm0, ill_o[0], tg0};
      1:       r = {cls1, lm1, ill_o[1], tg1};
      default: r = {cls2, lm2, ill_o[2], tg2};
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic push(input int d, input res_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic check_pop(input int d);
    res_t got, e;
    int   n;
    got = cur(d);
    n = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    checks++;
    if (n == 0) begin
      errors++;
      $display("FAIL unexpected_out dut%0d: got tag %h, required no output", d, got.tag);
    end else begin
      case (d)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      if (got !== e) begin
        errors++;
        $display("FAIL result dut%0d: got cls=%h mask=%h ill=%b tag=%h, required cls=%h mask=%h ill=%b tag=%h",
                 d, got.cls, got.mask, got.ill, got.tag, e.cls, e.mask, e.ill, e.tag);
      end
    end
  endtask

  // Output monitor: at the falling edge, a valid&ready pair means a handshake at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (ov[0] && rdy[0]) check_pop(0);
      if (ov[1] && rdy[1]) check_pop(1);
      if (ov[2] && rdy[2]) check_pop(2);
    end
  end

  // Present one op (called at posedge+1); returns at posedge+1 after the accepting edge.
  task automatic send_op(input int d, input logic [63:0] op, input logic [2:0] f,
                         input logic [3:0] t, input res_t e);
    int guard;
    operand = op; fmt = f; tag = t; vld[d] = 1'b1;
    #1;
    guard = 0;
    while (!in_rdy[d] && guard < 40) begin
      @(posedge clk); #2;
      guard++;
    end
    if (!in_rdy[d]) begin
      checks++; errors++;
      $display("FAIL accept_timeout dut%0d: got in_ready 0, required 1", d);
    end else begin
      push(d, e);
    end
    @(posedge clk); #1;
    vld[d] = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending, required 0", q0.size() + q1.size() + q2.size());
    end
  endtask

  res_t e, snap;
  logic [9:0] stream_l0 [5];

  initial begin
    rst = 1'b1; flush = 1'b0; vld = 3'b000; rdy = 3'b111;
    operand = 64'h0; fmt = 3'd0; tag = 4'h0;
    stream_l0 = '{10'h010, 10'h020, 10'h020, 10'h020, 10'h040};

    tv[0]  = '{0, 64'hFF800000_3F800000, 3'd0, {60'h0, 10'h001, 10'h040}, 8'h03, 1'b0};
    tv[1]  = '{0, 64'h7E00_7C01_8000_0001, 3'd2, {40'h0, 10'h200, 10'h100, 10'h008, 10'h020}, 8'h0F, 1'b0};
    tv[2]  = '{1, 64'hFFFFFFFF_00000000, 3'd0, {70'h0, 10'h010}, 8'h01, 1'b0};
    tv[3]  = '{1, 64'h7FFFFFFF_00000000, 3'd0, {70'h0, 10'h200}, 8'h01, 1'b0};
    tv[4]  = '{0, 64'h12345678_9ABCDEF0, 3'd6, 80'h0, 8'h00, 1'b1};
    tv[5]  = '{0, 64'h00000000_0000007C, 3'd3, {10'h010, 10'h010, 10'h010, 10'h010,
                                               10'h010, 10'h010, 10'h010, 10'h080}, 8'hFF, 1'b0};
    tv[6]  = '{0, 64'h80000000_00000001, 3'd1, {70'h0, 10'h004}, 8'h01, 1'b0};
    tv[7]  = '{0, 64'hFF80_7FC0_0080_0040, 3'd4, {40'h0, 10'h001, 10'h200, 10'h040, 10'h020}, 8'h0F, 1'b0};
    tv[8]  = '{0, 64'h80000000_7F800001, 3'd0, {60'h0, 10'h008, 10'h100}, 8'h03, 1'b0};
    tv[9]  = '{0, 64'h00000000_807FFFFF, 3'd0, {60'h0, 10'h010, 10'h004}, 8'h03, 1'b0};
    tv[10] = '{1, 64'hFFFFFFFF_FFFFC000, 3'd2, {70'h0, 10'h002}, 8'h01, 1'b0};
    tv[11] = '{1, 64'h7FF00000_00000000, 3'd1, {70'h0, 10'h080}, 8'h01, 1'b0};
    tv[12] = '{1, 64'hFFFFFFFF_FFFFFF83, 3'd3, {70'h0, 10'h004}, 8'h01, 1'b0};
    tv[13] = '{1, 64'h0000FFFF_FFFF3C00, 3'd2, {70'h0, 10'h200}, 8'h01, 1'b0};
    tv[14] = '{1, 64'hFFFFFFFF_FFFF7F80, 3'd4, {70'h0, 10'h080}, 8'h01, 1'b0};
    tv[15] = '{1, 64'h00000000_3F800000, 3'd7, 80'h0, 8'h00, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_data_d%0d", d), 96'(cur(d)), 96'h0);
      chk($sformatf("rst_valid_d%0d", d), 96'(ov[d]), 96'h0);
      chk($sformatf("rst_busy_d%0d", d), 96'(busy[d]), 96'h0);
    end
    rst = 1'b0;

    // Table-driven classification vectors.
    for (int i = 0; i < 16; i++) begin
      e.cls = tv[i].cls; e.mask = tv[i].mask; e.ill = tv[i].ill; e.tag = 4'(i);
      send_op(tv[i].d, tv[i].op, tv[i].f, 4'(i), e);
    end
    drain();

    // Latency: one cycle for the N=1 instance, two for the N=2 instance.
    e = {{70'h0, 10'h040}, 8'h01, 1'b0, 4'h3};
    send_op(0, 64'h3FF00000_00000000, 3'd1, 4'h3, e);
    chk("lat1_valid", 96'(ov[0]), 96'h1);
    drain();
    e = {{70'h0, 10'h080}, 8'h01, 1'b0, 4'h5};
    send_op(2, 64'hFFF00000_00000000 & 64'h7FFFFFFF_FFFFFFFF, 3'd1, 4'h5, e);
    chk("lat2_valid_early", 96'(ov[2]), 96'h0);
    @(posedge clk); #1;
    chk("lat2_valid", 96'(ov[2]), 96'h1);
    drain();

    // Stream 5 ops into the N=2 instance with the output stalled for cycles 3-6.
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          res_t es;
          es = {{10'h010, 10'h010, 10'h010, 10'h010, 10'h010, 10'h010, 10'h010, stream_l0[k]},
                8'hFF, 1'b0, 4'(k + 8)};
          send_op(2, 64'(k), 3'd3, 4'(k + 8), es);
        end
      end
      begin
        for (int c = 0; c < 8; c++) begin
          rdy[2] = (c >= 3 && c <= 6) ? 1'b0 : 1'b1;
          #1;
          if (c == 3) snap = cur(2);
          if (c >= 3 && c <= 6) begin
            chk($sformatf("stall_in_ready_c%0d", c), 96'(in_rdy[2]), 96'h0);
            chk($sformatf("stall_valid_c%0d", c), 96'(ov[2]), 96'h1);
          end
          if (c > 3 && c <= 6) chk($sformatf("stall_hold_c%0d", c), 96'(cur(2)), 96'(snap));
          @(posedge clk); #1;
        end
      end
    join
    drain();

    // Flush with two ops in flight, then flush alongside a new input.
    rdy[2] = 1'b0;
    send_op(2, 64'h0, 3'd0, 4'h1, {{60'h0, 10'h010, 10'h010}, 8'h03, 1'b0, 4'h1});
    send_op(2, 64'h0, 3'd0, 4'h2, {{60'h0, 10'h010, 10'h010}, 8'h03, 1'b0, 4'h2});
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    q2.delete();
    chk("flush_valid", 96'(ov[2]), 96'h0);
    chk("flush_busy", 96'(busy[2]), 96'h0);
    rdy[2] = 1'b1;
    flush = 1'b1; vld[2] = 1'b1; operand = 64'h3F800000_3F800000; fmt = 3'd0; tag = 4'h7;
    #1;
    chk("flush_in_ready", 96'(in_rdy[2]), 96'h1);
    @(posedge clk); #1;
    flush = 1'b0; vld[2] = 1'b0;
    @(posedge clk); #1;
    chk("flush_drop_valid", 96'(ov[2]), 96'h0);
    chk("flush_drop_busy", 96'(busy[2]), 96'h0);
    send_op(2, 64'h3F800000_BF800000, 3'd0, 4'hC, {{60'h0, 10'h040, 10'h002}, 8'h03, 1'b0, 4'hC});
    drain();

    // Reset with two ops in flight.
    rdy[2] = 1'b0;
    send_op(2, 64'h0, 3'd2, 4'h9, {{40'h0, 10'h010, 10'h010, 10'h010, 10'h010}, 8'h0F, 1'b0, 4'h9});
    send_op(2, 64'h0, 3'd2, 4'hA, {{40'h0, 10'h010, 10'h010, 10'h010, 10'h010}, 8'h0F, 1'b0, 4'hA});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q2.delete();
    chk("mrst_data", 96'(cur(2)), 96'h0);
    chk("mrst_valid", 96'(ov[2]), 96'h0);
    chk("mrst_busy", 96'(busy[2]), 96'h0);
    rdy[2] = 1'b1;
    send_op(2, 64'h7C00_0000_0000_0000, 3'd2, 4'hD,
            {{40'h0, 10'h080, 10'h010, 10'h010, 10'h010}, 8'h0F, 1'b0, 4'hD});
    drain();

    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", 96'(q0.size() + q1.size() + q2.size()), 96'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpnew_classifier_multi.md
Name: fpnew_classifier_multi

Overview:
- Decoding end of the FPU format encodings: unpacks raw operand bits into per-lane 10-bit classification masks (one-hot NEGINF..QNAN encoding).
- Supports all five FP formats (FP32, FP64, FP16, FP8, FP16ALT), scalar with NaN-box check or packed-vector, behind a valid/ready pipeline of configurable depth.
- Sits as the CLASS opgroup slice next to the NONCOMP/CONV slices.

Parameters:
- WIDTH, 64, operand width in bits; must be a multiple of 16 and >= 64.
- ENABLE_VECTORS, 1, 1 classifies all lanes of a packed vector; 0 classifies lane 0 only, with NaN-box check.
- NUM_PIPE_REGS, 1, register stages between input and output; 0 is a combinational pass-through.
- TAG_WIDTH, 4, width of the opaque tag carried alongside the data.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- operand_i  in  WIDTH  raw operand bits
- fmt_i  in  3  format: 0 FP32, 1 FP64, 2 FP16, 3 FP8, 4 FP16ALT; 5-7 illegal
- tag_i  in  TAG_WIDTH  tag
- in_valid_i  in  1  input valid
- in_ready_o  out  1  input ready
- flush_i  in  1  kill all in-flight operations
- class_o  out  10*(WIDTH/8)  lane k mask at bits [10k+9:10k]
- lane_mask_o  out  WIDTH/8  lanes that carry a valid class
- illegal_fmt_o  out  1  fmt_i was 5-7
- tag_o  out  TAG_WIDTH  tag
- out_valid_o  out  1  output valid
- out_ready_i  in  1  output ready
- busy_o  out  1  any stage holds a valid operation

Behaviour:
- Reset is synchronous and active-high on rst_i; single clock clk_i.
  - Reset clears all stage valid bits and data registers.
  - Post-reset outputs: out_valid_o=0, class_o=0, lane_mask_o=0, illegal_fmt_o=0, tag_o=0, busy_o=0.
  - Reset asserted mid-operation drops all in-flight operations; no output handshake occurs for them.
- Format encodings (exp, man): FP32 8/23, FP64 11/52, FP16 5/10, FP8 5/2, FP16ALT 8/7.
- Lane count:
  - n = WIDTH/(1+exp+man) when ENABLE_VECTORS=1; otherwise n = 1.
  - lane_mask_o[k] = 1 for k < n; all other class_o bits are 0.
- Per-lane classification: exponent all-ones with mantissa 0 is +/-INF.
  - Exponent all-ones with mantissa != 0 is NaN: QNAN (0x200) if the mantissa MSB is 1, else SNAN (0x100).
  - Exponent 0 with mantissa 0 is +/-ZERO (0x010/0x008).
  - Exponent 0 with mantissa != 0 is +/-SUBNORM (0x020/0x004).
  - Otherwise +/-NORM (0x040/0x002). INF codes are 0x080/0x001.
- NaN-boxing applies only when ENABLE_VECTORS=0 and the format width < WIDTH.
  - If any bit above the format width is 0, the operand is unboxed and lane 0 reports QNAN (0x200).
- Illegal fmt_i: the operation still flows through the pipeline, with lane_mask_o=0, class_o=0 and illegal_fmt_o=1.
- Pipeline of NUM_PIPE_REGS stages, each holding a valid bit plus its data.
  - Stage i loads when it is empty or when stage i+1 accepts; the last stage loads when out_valid_o=0 or out_ready_i=1.
  - in_ready_o is the stage-0 accept condition.
  - Bubbles collapse, so full throughput is 1 op/cycle with out_ready_i held high.
  - Latency is exactly NUM_PIPE_REGS cycles from an input handshake to out_valid_o with no backpressure.
- NUM_PIPE_REGS=0: outputs are combinational from the inputs; in_ready_o = out_ready_i; out_valid_o = in_valid_i; busy_o = 0.
- Handshake rule: while out_valid_o=1 and out_ready_i=0, the output data and tag hold stable.
- flush_i: all valid bits clear at the next edge.
  - An input presented in the same cycle as flush_i is dropped.
  - in_ready_o is unaffected by flush_i.
- busy_o is the OR of all stage valid bits (registered path only).

Test Plan:
- NUM_PIPE_REGS=1, vectors on: fmt=FP32, operand 0xFF800000_3F800000 -> after 1 cycle, class_o lane0=0x040, lane1=0x001, lane_mask_o=0x03.
- Vectors on: fmt=FP16, operand 0x7E00_7C01_8000_0001 -> lane0=0x020, lane1=0x008, lane2=0x100, lane3=0x200, lane_mask_o=0x0F.
- ENABLE_VECTORS=0: fmt=FP32, operand 0xFFFFFFFF_00000000 -> lane0=0x010; operand 0x7FFFFFFF_00000000 -> lane0=0x200 (unboxed).
- NUM_PIPE_REGS=2: stream 5 ops with out_ready_i low for cycles 3-6.
  - Outputs hold stable while stalled; in_ready_o drops once both stages are full.
  - All 5 tags emerge in order, with none lost or duplicated.
- Two ops in flight, assert flush_i for one cycle -> out_valid_o=0 and busy_o=0 the next cycle; a new op then completes normally. Repeat with rst_i instead of flush_i -> same outcome and all outputs zero.
- fmt_i=6 -> illegal_fmt_o=1, lane_mask_o=0, class_o=0, tag preserved; fmt=FP8, operand 0x7C -> lane0=0x080, lane_mask_o=0xFF.
